axi4_burst_mem_slave: RTL and testbench
=======================================

// Module: axi4_burst_mem_slave
// PURPOSE
//  AXI4 (full) slave responder: small on-chip word memory that accepts INCR write
//  bursts and serves INCR read bursts. It is the counterpart of the controller_AXI
//  burst master and is the DUT-side target for the master's write/read/compare test.
//  Separate write and read FSMs; one outstanding transaction per direction; no IDs.
// PARAMETERS
//  DATA_WIDTH  32  data bus width in bits; only 32 is supported (byte lane = WSTRB bit)
//  ADDR_WIDTH  10  byte-address width; memory = 2**(ADDR_WIDTH-2) words, addresses wrap
// PORTS
//  ACLK         in   1             clock, all logic on rising edge
//  ARESETN      in   1             synchronous reset, active-low
//  S_AXI_AWADDR in   ADDR_WIDTH    write burst start byte address (bits [1:0] ignored)
//  S_AXI_AWLEN  in   8             write beats minus one
//  S_AXI_AWVALID in  1             AW valid
//  S_AXI_AWREADY out 1             AW ready
//  S_AXI_WDATA  in   DATA_WIDTH    write data
//  S_AXI_WSTRB  in   DATA_WIDTH/8  byte enables
//  S_AXI_WLAST  in   1             last write beat
//  S_AXI_WVALID in   1             W valid
//  S_AXI_WREADY out  1             W ready
//  S_AXI_BRESP  out  2             write response (00 OKAY, 10 SLVERR)
//  S_AXI_BVALID out  1             B valid
//  S_AXI_BREADY in   1             B ready
//  S_AXI_ARADDR in   ADDR_WIDTH    read burst start byte address (bits [1:0] ignored)
//  S_AXI_ARLEN  in   8             read beats minus one
//  S_AXI_ARVALID in  1             AR valid
//  S_AXI_ARREADY out 1             AR ready
//  S_AXI_RDATA  out  DATA_WIDTH    read data
//  S_AXI_RRESP  out  2             read response, always 00
//  S_AXI_RLAST  out  1             last read beat
//  S_AXI_RVALID out  1             R valid
//  S_AXI_RREADY in   1             R ready
// BEHAVIOUR
//  Reset (ARESETN=0 at an edge): all READY/VALID outputs 0, RLAST 0, BRESP/RRESP/RDATA 0,
//   both FSMs -> IDLE, error flag cleared. Memory array is NOT reset. A reset mid-burst
//   abandons the burst; beats already written stay in memory. All outputs are registered.
//  AxSIZE/AxBURST are not ports: full-width INCR only. Word index = addr[ADDR_WIDTH-1:2],
//   incremented per beat modulo memory depth (top word -> word 0).
//  Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
//   W_IDLE: AWREADY=1, WREADY=0 (W beats before AW stall). AW handshake latches word index,
//    beat counter=AWLEN, err=0 -> W_DATA; AWREADY=0 from the next cycle.
//   W_DATA: WREADY=1. Each WVALID beat writes enabled bytes, index+1, counter-1.
//    WLAST on beat with counter!=0: err=1, burst ends early (-> W_RESP).
//    Counter==0 beat without WLAST: beat written, err=1. Counter==0 -> W_RESP.
//   W_RESP: BVALID=1, BRESP = err ? 2'b10 : 2'b00; held stable until BREADY, then W_IDLE
//    (AWREADY=1 the cycle after the B handshake).
//  Read FSM R_IDLE -> R_DATA -> R_IDLE:
//   R_IDLE: ARREADY=1. AR handshake at edge N: RDATA<=mem[index], RLAST<=(ARLEN==0),
//    RVALID=1 after edge N (first beat latency 1 cycle); ARREADY=0.
//   R_DATA: RDATA/RLAST/RVALID held stable while RVALID & !RREADY. On RREADY: if RLAST ->
//    RVALID=0, R_IDLE; else load next word, one beat per cycle with RREADY held high.
//  Read and write run concurrently. Same-word same-edge write and read load: read gets
//   the old value; writes committed at earlier edges are visible.
//  AxLEN=0 is a single-beat burst; AxLEN=255 gives 256 beats.
// TESTING
//  1 AW 0x040 len=15, WDATA 1..16 strb F, then AR 0x040 len=15 -> BRESP 00, RDATA 1..16, RLAST beat 16 only
//  2 Same read with RREADY 1,0,1,0... -> each beat held while RREADY=0, 16 beats, no drop/repeat
//  3 Write 0x00000000 to 0x100, then 0xFFFFFFFF strb 0101 -> read 0x100 returns 0x00FF00FF
//  4 AW 0x3FC len=1 data A,B -> word 255=A, word 0=B; AR 0x3FC len=1 returns A,B
//  5 AW len=7 with WLAST on beat 3 -> BRESP 10, exactly 3 words changed, AWREADY 1 after B handshake
//  6 ARESETN low 1 cycle during beat 2 of 8-beat read -> RVALID 0 next edge, ARREADY 1 after release, new read correct

Source files
------------

// File: rtl/axi4_burst_mem_slave.sv
// rtl/axi4_burst_mem_slave.sv - AXI4 INCR-burst word memory slave with independent write and read FSMs
module axi4_burst_mem_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]              S_AXI_AWLEN,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]              S_AXI_ARLEN,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RLAST,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IW;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA} rstate_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  wstate_t         wstate_q, wstate_d;
  logic [IW-1:0]   widx_q, widx_d;
  logic [7:0]      wcnt_q, wcnt_d;
  logic            werr_q, werr_d;
  logic            awready_q, awready_d;
  logic            wready_q, wready_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            mem_we;

  rstate_t         rstate_q, rstate_d;
  logic [IW-1:0]   ridx_q, ridx_d;
  logic [7:0]      rcnt_q, rcnt_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic            rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [IW-1:0]   aw_idx, ar_idx;
  logic            unused_addr_lsbs;

  // Byte address bits [1:0] do not select anything: full-width beats only.
  assign aw_idx           = S_AXI_AWADDR[ADDR_WIDTH-1:2];
  assign ar_idx           = S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write FSM next state; an early WLAST or a missing WLAST both flag SLVERR.
  always_comb begin
    wstate_d = wstate_q;
    widx_d   = widx_q;
    wcnt_d   = wcnt_q;
    werr_d   = werr_q;
    mem_we   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (S_AXI_AWVALID && awready_q) begin
          widx_d   = aw_idx;
          wcnt_d   = S_AXI_AWLEN;
          werr_d   = 1'b0;
          wstate_d = W_DATA;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID && wready_q) begin
          mem_we = 1'b1;
          widx_d = widx_q + 1'b1;
          wcnt_d = wcnt_q - 1'b1;
          if (wcnt_q == 8'd0) begin
            if (!S_AXI_WLAST) werr_d = 1'b1;
            wstate_d = W_RESP;
          end else if (S_AXI_WLAST) begin
            werr_d   = 1'b1;
            wstate_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY && bvalid_q) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
    awready_d = (wstate_d == W_IDLE);
    wready_d  = (wstate_d == W_DATA);
    bvalid_d  = (wstate_d == W_RESP);
    bresp_d   = ((wstate_d == W_RESP) && werr_d) ? 2'b10 : 2'b00;
  end

  // Write FSM registers and registered write-channel outputs.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wstate_q  <= W_IDLE;
      widx_q    <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      wstate_q  <= wstate_d;
      widx_q    <= widx_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Byte-masked memory write; the array itself is never cleared.
  always_ff @(posedge ACLK) begin
    if (ARESETN && mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (S_AXI_WSTRB[b]) mem[widx_q][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // Read FSM next state; loads read the array before this edge's write lands.
  always_comb begin
    rstate_d = rstate_q;
    ridx_d   = ridx_q;
    rcnt_d   = rcnt_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    rdata_d  = rdata_q;
    case (rstate_q)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          rdata_d  = mem[ar_idx];
          rlast_d  = (S_AXI_ARLEN == 8'd0);
          rvalid_d = 1'b1;
          ridx_d   = ar_idx + 1'b1;
          rcnt_d   = S_AXI_ARLEN;
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY && rvalid_q) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            rstate_d = R_IDLE;
          end else begin
            rdata_d = mem[ridx_q];
            ridx_d  = ridx_q + 1'b1;
            rcnt_d  = rcnt_q - 1'b1;
            rlast_d = (rcnt_q == 8'd1);
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
  end

  // Read FSM registers and registered read-channel outputs.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rstate_q  <= R_IDLE;
      ridx_q    <= '0;
      rcnt_q    <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rstate_q  <= rstate_d;
      ridx_q    <= ridx_d;
      rcnt_q    <= rcnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// tb/tb_axi4_burst_mem_slave.sv - directed self-checking bench for axi4_burst_mem_slave
module tb_axi4_burst_mem_slave;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [9:0]  awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [9:0]  araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wbuf [256];
  logic [31:0] rbuf [256];
  int          r_got;
  int          r_lastidx;
  int          r_holdbad;

  always #5 clk = ~clk;

  axi4_burst_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .ACLK          (clk),
    .ARESETN       (aresetn),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWLEN   (awlen),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WLAST   (wlast),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARLEN   (arlen),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RLAST   (rlast),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  task automatic write_burst(input logic [9:0] addr, input logic [7:0] len, input int nbeats,
                             input int last_at, input logic [3:0] strb,
                             output logic [1:0] resp, output bit ok);
    ok = 1'b1;
    @(negedge clk);
    awaddr = addr; awlen = len; awvalid = 1'b1;
    for (int t = 0; t < 100 && !awready; t++) @(negedge clk);
    if (!awready) ok = 1'b0;
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clk);
      wdata = wbuf[i]; wstrb = strb; wlast = (i == last_at); wvalid = 1'b1;
      for (int t = 0; t < 100 && !wready; t++) @(negedge clk);
      if (!wready) ok = 1'b0;
    end
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    for (int t = 0; t < 100 && !bvalid; t++) @(negedge clk);
    if (!bvalid) ok = 1'b0;
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic start_read(input logic [9:0] addr, input logic [7:0] len, output bit ok);
    @(negedge clk);
    araddr = addr; arlen = len; arvalid = 1'b1;
    for (int t = 0; t < 100 && !arready; t++) @(negedge clk);
    ok = arready;
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  // mode 0: RREADY always high; mode 1: RREADY 1,0,1,0...
  task automatic read_burst(input logic [9:0] addr, input logic [7:0] len, input int mode,
                            output bit ok);
    bit          held, done;
    logic [31:0] hd;
    logic        hl;
    start_read(addr, len, ok);
    r_got = 0; r_lastidx = -1; r_holdbad = 0; held = 1'b0; done = 1'b0;
    hd = '0; hl = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      rready = (mode == 0) ? 1'b1 : ((c % 2) == 0);
      if (held) begin
        if (!rvalid || rdata !== hd || rlast !== hl) r_holdbad++;
        held = 1'b0;
      end
      if (rvalid) begin
        if (rready) begin
          if (r_got < 256) rbuf[r_got] = rdata;
          if (rlast) begin
            r_lastidx = r_got;
            done = 1'b1;
          end
          r_got++;
        end else begin
          held = 1'b1; hd = rdata; hl = rlast;
        end
      end
    end
    if (!done) ok = 1'b0;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
      n_bad++; $display("FAIL reset_handshakes got %b exp 000000", {awready, wready, bvalid, arready, rvalid, rlast});
    end
    n_cmp++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      n_bad++; $display("FAIL reset_data got bresp=%b rresp=%b rdata=%h exp zeros", bresp, rresp, rdata);
    end
    wvalid = 1'b1;
    aresetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({awready, arready, wready, bvalid, rvalid} !== 5'b11000) begin
      n_bad++; $display("FAIL post_reset_ready got %b exp 11000", {awready, arready, wready, bvalid, rvalid});
    end
    wvalid = 1'b0;
  endtask

  task automatic test_incr_burst();
    logic [1:0] resp;
    bit ok;
    for (int i = 0; i < 16; i++) wbuf[i] = 32'(i + 1);
    write_burst(10'h040, 8'd15, 16, 15, 4'hF, resp, ok);
    n_cmp++;
    if (!ok || resp !== 2'b00) begin
      n_bad++; $display("FAIL incr_bresp got ok=%0d resp=%b exp ok=1 resp=00", ok, resp);
    end
    read_burst(10'h040, 8'd15, 0, ok);
    n_cmp++;
    if (!ok || r_got !== 16 || r_lastidx !== 15) begin
      n_bad++; $display("FAIL incr_beats got ok=%0d beats=%0d last=%0d exp 1/16/15", ok, r_got, r_lastidx);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (rbuf[i] !== 32'(i + 1)) begin
        n_bad++; $display("FAIL incr_rdata[%0d] got %h exp %h", i, rbuf[i], 32'(i + 1));
      end
    end
    n_cmp++;
    if (rvalid !== 1'b0) begin
      n_bad++; $display("FAIL incr_rvalid_end got %b exp 0", rvalid);
    end
  endtask

  task automatic test_rready_throttle();
    bit ok;
    int bad;
    read_burst(10'h040, 8'd15, 1, ok);
    n_cmp++;
    if (!ok || r_got !== 16 || r_lastidx !== 15) begin
      n_bad++; $display("FAIL throttle_beats got ok=%0d beats=%0d last=%0d exp 1/16/15", ok, r_got, r_lastidx);
    end
    n_cmp++;
    if (r_holdbad !== 0) begin
      n_bad++; $display("FAIL throttle_hold got %0d unstable beats exp 0", r_holdbad);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (rbuf[i] !== 32'(i + 1)) bad++;
    n_cmp++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL throttle_rdata got %0d wrong words exp 0", bad);
    end
  endtask

  task automatic test_strobes();
    logic [1:0] resp;
    bit ok;
    wbuf[0] = 32'h0000_0000;
    write_burst(10'h100, 8'd0, 1, 0, 4'hF, resp, ok);
    wbuf[0] = 32'hFFFF_FFFF;
    write_burst(10'h100, 8'd0, 1, 0, 4'b0101, resp, ok);
    n_cmp++;
    if (!ok || resp !== 2'b00) begin
      n_bad++; $display("FAIL strb_bresp got ok=%0d resp=%b exp 1/00", ok, resp);
    end
    read_burst(10'h100, 8'd0, 0, ok);
    n_cmp++;
    if (!ok || r_lastidx !== 0 || rbuf[0] !== 32'h00FF_00FF) begin
      n_bad++; $display("FAIL strb_rdata got ok=%0d last=%0d data=%h exp 1/0/00ff00ff", ok, r_lastidx, rbuf[0]);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] resp;
    bit ok;
    wbuf[0] = 32'hAAAA_0001;
    wbuf[1] = 32'hBBBB_0002;
    write_burst(10'h3FC, 8'd1, 2, 1, 4'hF, resp, ok);
    n_cmp++;
    if (!ok || resp !== 2'b00) begin
      n_bad++; $display("FAIL wrap_bresp got ok=%0d resp=%b exp 1/00", ok, resp);
    end
    read_burst(10'h3FC, 8'd1, 0, ok);
    n_cmp++;
    if (!ok || r_got !== 2 || rbuf[0] !== 32'hAAAA_0001 || rbuf[1] !== 32'hBBBB_0002) begin
      n_bad++; $display("FAIL wrap_read got beats=%0d %h %h exp 2 aaaa0001 bbbb0002", r_got, rbuf[0], rbuf[1]);
    end
    read_burst(10'h000, 8'd0, 0, ok);
    n_cmp++;
    if (!ok || rbuf[0] !== 32'hBBBB_0002) begin
      n_bad++; $display("FAIL wrap_word0 got %h exp bbbb0002", rbuf[0]);
    end
  endtask

  task automatic test_early_wlast();
    logic [1:0] resp;
    bit ok;
    logic [31:0] exp_w;
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h5000_0000 + 32'(i);
    write_burst(10'h200, 8'd7, 8, 7, 4'hF, resp, ok);
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hC000_0000 + 32'(i);
    write_burst(10'h200, 8'd7, 3, 2, 4'hF, resp, ok);
    n_cmp++;
    if (!ok || resp !== 2'b10) begin
      n_bad++; $display("FAIL early_wlast_bresp got ok=%0d resp=%b exp 1/10", ok, resp);
    end
    n_cmp++;
    if (awready !== 1'b1) begin
      n_bad++; $display("FAIL early_wlast_awready got %b exp 1", awready);
    end
    read_burst(10'h200, 8'd7, 0, ok);
    for (int i = 0; i < 8; i++) begin
      exp_w = (i < 3) ? (32'hC000_0000 + 32'(i)) : (32'h5000_0000 + 32'(i));
      n_cmp++;
      if (rbuf[i] !== exp_w) begin
        n_bad++; $display("FAIL early_wlast_word[%0d] got %h exp %h", i, rbuf[i], exp_w);
      end
    end
  endtask

  task automatic test_missing_wlast();
    logic [1:0] resp;
    bit ok;
    wbuf[0] = 32'h7700_0000;
    wbuf[1] = 32'h7700_0001;
    write_burst(10'h300, 8'd1, 2, -1, 4'hF, resp, ok);
    n_cmp++;
    if (!ok || resp !== 2'b10) begin
      n_bad++; $display("FAIL missing_wlast_bresp got ok=%0d resp=%b exp 1/10", ok, resp);
    end
    read_burst(10'h300, 8'd1, 0, ok);
    n_cmp++;
    if (rbuf[0] !== 32'h7700_0000 || rbuf[1] !== 32'h7700_0001) begin
      n_bad++; $display("FAIL missing_wlast_data got %h %h exp 77000000 77000001", rbuf[0], rbuf[1]);
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int bad;
    start_read(10'h040, 8'd7, ok);
    n_cmp++;
    if (!ok || rvalid !== 1'b1 || rdata !== 32'h1) begin
      n_bad++; $display("FAIL midrst_beat1 got ok=%0d rvalid=%b rdata=%h exp 1/1/00000001", ok, rvalid, rdata);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== 32'h2) begin
      n_bad++; $display("FAIL midrst_beat2 got rvalid=%b rdata=%h exp 1/00000002", rvalid, rdata);
    end
    aresetn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rvalid !== 1'b0 || arready !== 1'b0) begin
      n_bad++; $display("FAIL midrst_in_reset got rvalid=%b arready=%b exp 0/0", rvalid, arready);
    end
    aresetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_release got arready=%b rvalid=%b exp 1/0", arready, rvalid);
    end
    read_burst(10'h040, 8'd3, 0, ok);
    bad = 0;
    for (int i = 0; i < 4; i++) if (rbuf[i] !== 32'(i + 1)) bad++;
    n_cmp++;
    if (!ok || r_got !== 4 || r_lastidx !== 3 || bad !== 0) begin
      n_bad++; $display("FAIL midrst_new_read got ok=%0d beats=%0d last=%0d bad=%0d exp 1/4/3/0", ok, r_got, r_lastidx, bad);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    test_reset();
    test_incr_burst();
    test_rready_throttle();
    test_strobes();
    test_wrap();
    test_early_wlast();
    test_missing_wlast();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
